vm_vend_engine: RTL

//  Parametrised next-generation vending core. Holds stock and price for N_ITEMS

---
 rtl/vm_vend_engine_pkg.sv | 27 ++
 rtl/vm_stock_bank.sv | 72 +++++++
 rtl/vm_vend_engine.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/vm_vend_engine_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : vm_vend_engine_pkg
//  Purpose  : Shared types for the vending core: event status codes and FSM states.
//  Revision : 1.0
// ============================================================================
package vm_vend_engine_pkg;

    typedef enum logic [2:0] {
        ST_OK         = 3'd0,
        ST_OVERFLOW   = 3'd1,
        ST_CREDIT_MAX = 3'd2,
        ST_SOLDOUT    = 3'd3,
        ST_LOW_CREDIT = 3'd4,
        ST_NO_CREDIT  = 3'd5,
        ST_BAD_ITEM   = 3'd6
    } status_t;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } vend_state_t;

endpackage
`default_nettype wire

// File: rtl/vm_stock_bank.sv
`default_nettype none
// ============================================================================
//  Module   : vm_stock_bank
//  Purpose  : Per-item stock/price register file with overflow-checked restock,
//             single-unit decrement, one read port and soldout flags.
//  Revision : 1.0
// ============================================================================
module vm_stock_bank #(
    parameter int N_ITEMS  = 8,
    parameter int STOCK_W  = 4,
    parameter int CREDIT_W = 16,
    localparam int IW      = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [IW-1:0]       wr_item,
    input  logic [STOCK_W-1:0]  wr_count,
    input  logic [CREDIT_W-1:0] wr_price,
    output logic                wr_ovf,
    input  logic                dec_en,
    input  logic [IW-1:0]       dec_item,
    input  logic [IW-1:0]       rd_item,
    output logic [STOCK_W-1:0]  rd_stock,
    output logic [CREDIT_W-1:0] rd_price,
    output logic [N_ITEMS-1:0]  soldout
);

    logic [STOCK_W-1:0]  stock_q [N_ITEMS];
    logic [STOCK_W-1:0]  stock_d [N_ITEMS];
    logic [CREDIT_W-1:0] price_q [N_ITEMS];
    logic [CREDIT_W-1:0] price_d [N_ITEMS];
    logic [STOCK_W:0]    w_wr_sum;

    // A carry out of the stock width means the sum exceeds 2**STOCK_W-1.
    assign w_wr_sum = {1'b0, stock_q[wr_item]} + {1'b0, wr_count};
    assign wr_ovf   = w_wr_sum[STOCK_W];
    assign rd_stock = stock_q[rd_item];
    assign rd_price = price_q[rd_item];

    always_comb begin
        stock_d = stock_q;
        price_d = price_q;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (wr_en && !wr_ovf && (wr_item == IW'(i))) begin
                stock_d[i] = w_wr_sum[STOCK_W-1:0];
                price_d[i] = wr_price;
            end
            if (dec_en && (dec_item == IW'(i)) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_ITEMS; i++) begin
                stock_q[i] <= '0;
                price_q[i] <= '0;
            end
        end else begin
            stock_q <= stock_d;
            price_q <= price_d;
        end
    end

    for (genvar g = 0; g < N_ITEMS; g++) begin : g_soldout
        assign soldout[g] = (stock_q[g] == '0);
    end

endmodule
`default_nettype wire

// File: rtl/vm_vend_engine.sv
`default_nettype none
// ============================================================================
//  Module   : vm_vend_engine
//  Purpose  : Vending core: coin credit, item selection, dispense and change FSM.
//  Revision : 1.0
// ============================================================================
module vm_vend_engine
    import vm_vend_engine_pkg::*;
#(
    parameter int N_ITEMS    = 8,
    parameter int STOCK_W    = 4,
    parameter int CREDIT_W   = 16,
    parameter int MAX_CREDIT = 1000,
    localparam int IW        = $clog2(N_ITEMS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [7:0]          coin_cents,
    output logic                coin_reject,
    input  logic                sel_valid,
    input  logic [IW-1:0]       sel_item,
    input  logic                cancel,
    input  logic                rs_valid,
    output logic                rs_ready,
    input  logic [IW-1:0]       rs_item,
    input  logic [STOCK_W-1:0]  rs_count,
    input  logic [CREDIT_W-1:0] rs_price,
    output logic                vend_valid,
    output logic [IW-1:0]       vend_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic [CREDIT_W-1:0] credit,
    output status_t             status,
    output logic [N_ITEMS-1:0]  soldout
);

    localparam int C_SUM_W = CREDIT_W + 1;

    vend_state_t         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    status_t             status_q, status_d;
    logic                coin_reject_q, coin_reject_d;
    logic [IW-1:0]       vend_item_q, vend_item_d;

    logic [C_SUM_W-1:0]  w_coin_sum;
    logic                w_coin_over;
    logic [CREDIT_W-1:0] w_remainder;
    logic                w_item_ok;
    logic                w_rs_fire;
    logic [IW-1:0]       w_rd_item;
    logic [STOCK_W-1:0]  w_rd_stock;
    logic [CREDIT_W-1:0] w_rd_price;
    logic                w_wr_ovf;

    if (2 ** IW == N_ITEMS) begin : g_item_pow2
        assign w_item_ok = 1'b1;
    end else begin : g_item_range
        assign w_item_ok = (int'(sel_item) < N_ITEMS);
    end

    assign w_coin_sum  = {1'b0, credit_q} + C_SUM_W'(coin_cents);
    assign w_coin_over = (w_coin_sum > C_SUM_W'(MAX_CREDIT));
    assign w_remainder = credit_q - w_rd_price;
    assign rs_ready    = (state_q == S_IDLE);
    assign w_rs_fire   = rs_valid && rs_ready;
    // While vending, the bank must keep pointing at the latched item.
    assign w_rd_item   = (state_q == S_VEND) ? vend_item_q : sel_item;

    vm_stock_bank #(
        .N_ITEMS  (N_ITEMS),
        .STOCK_W  (STOCK_W),
        .CREDIT_W (CREDIT_W)
    ) u_stock_bank (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (w_rs_fire),
        .wr_item  (rs_item),
        .wr_count (rs_count),
        .wr_price (rs_price),
        .wr_ovf   (w_wr_ovf),
        .dec_en   (state_q == S_VEND),
        .dec_item (vend_item_q),
        .rd_item  (w_rd_item),
        .rd_stock (w_rd_stock),
        .rd_price (w_rd_price),
        .soldout  (soldout)
    );

    always_comb begin
        state_d       = state_q;
        credit_d      = credit_q;
        status_d      = status_q;
        coin_reject_d = 1'b0;
        vend_item_d   = vend_item_q;

        if (w_rs_fire) begin
            status_d = w_wr_ovf ? ST_OVERFLOW : ST_OK;
        end

        case (state_q)
            S_IDLE, S_CREDIT: begin
                // Priority cancel > coin > select; a coin lost to cancel is returned.
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    if (state_q == S_CREDIT) begin
                        state_d = S_CHANGE;
                    end
                end else if (coin_valid) begin
                    if (w_coin_over) begin
                        coin_reject_d = 1'b1;
                        status_d      = ST_CREDIT_MAX;
                    end else begin
                        credit_d = w_coin_sum[CREDIT_W-1:0];
                        state_d  = S_CREDIT;
                    end
                end else if (sel_valid) begin
                    if (!w_item_ok) begin
                        status_d = ST_BAD_ITEM;
                    end else if (state_q == S_IDLE) begin
                        status_d = ST_NO_CREDIT;
                    end else if (w_rd_stock == '0) begin
                        status_d = ST_SOLDOUT;
                    end else if (credit_q < w_rd_price) begin
                        status_d = ST_LOW_CREDIT;
                    end else begin
                        vend_item_d = sel_item;
                        status_d    = ST_OK;
                        state_d     = S_VEND;
                    end
                end
            end
            S_VEND: begin
                coin_reject_d = coin_valid;
                credit_d      = w_remainder;
                state_d       = (w_remainder != '0) ? S_CHANGE : S_IDLE;
            end
            S_CHANGE: begin
                coin_reject_d = coin_valid;
                credit_d      = '0;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            credit_q      <= '0;
            status_q      <= ST_OK;
            coin_reject_q <= 1'b0;
            vend_item_q   <= '0;
        end else begin
            state_q       <= state_d;
            credit_q      <= credit_d;
            status_q      <= status_d;
            coin_reject_q <= coin_reject_d;
            vend_item_q   <= vend_item_d;
        end
    end

    assign coin_reject  = coin_reject_q;
    assign vend_valid   = (state_q == S_VEND);
    assign vend_item    = vend_item_q;
    assign change_valid = (state_q == S_CHANGE);
    assign change_amt   = change_valid ? credit_q : '0;
    assign credit       = credit_q;
    assign status       = status_q;

endmodule
`default_nettype wire
